// File: rtl/ins_mem.sv
// Instruction memory: synchronous-read program store with a registered output word.
// Define INS_MEM_WRITE_EN to add a run-time write port (wEn/wAddr/wData).
module ins_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int INS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rEn,
  input  logic [ADDR_WIDTH-1:0] PC_address,
`ifdef INS_MEM_WRITE_EN
  input  logic                  wEn,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [INS_WIDTH-1:0]  wData,
`endif
  output logic [INS_WIDTH-1:0]  instruction
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Program image as bytes; the size cast zero-extends or truncates to INS_WIDTH.
  function automatic logic [INS_WIDTH-1:0] f_word(input int unsigned idx);
    logic [7:0] b;
    case (idx)
      0:  b = 8'h10;
      1:  b = 8'h21;
      2:  b = 8'h32;
      3:  b = 8'h43;
      4:  b = 8'h54;
      5:  b = 8'h65;
      6:  b = 8'h76;
      7:  b = 8'h87;
      8:  b = 8'h98;
      9:  b = 8'hA9;
      10: b = 8'hBA;
      11: b = 8'hCB;
      12: b = 8'hDC;
      13: b = 8'hED;
      14: b = 8'hFE;
      15: b = 8'hFF;
      default: b = 8'h00;
    endcase
    return INS_WIDTH'(b);
  endfunction

  logic [INS_WIDTH-1:0] r_instr;
  logic [INS_WIDTH-1:0] w_rd;

`ifdef INS_MEM_WRITE_EN
  typedef logic [DEPTH-1:0][INS_WIDTH-1:0] img_t;

  function automatic img_t f_image();
    img_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = f_word(i);
    return img;
  endfunction

  // Loaded at configuration; reset deliberately leaves the contents alone.
  img_t r_mem = f_image();

  assign w_rd = r_mem[PC_address];

  always_ff @(posedge clk) begin
    if (!rst && wEn) r_mem[wAddr] <= wData;
  end
`else
  assign w_rd = f_word(32'(PC_address));
`endif

  // Non-blocking read of r_mem gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst)      r_instr <= '0;
    else if (rEn) r_instr <= w_rd;
  end

  assign instruction = r_instr;

endmodule

// File: tb/tb_ins_mem.sv
// Directed, table-driven bench for ins_mem (8-bit address, 8-bit words).
module tb_ins_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       rEn;
  logic [7:0] PC_address;
  logic [7:0] instruction;
`ifdef INS_MEM_WRITE_EN
  logic       wEn;
  logic [7:0] wAddr;
  logic [7:0] wData;
`endif

  ins_mem #(.ADDR_WIDTH(8), .INS_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rEn         (rEn),
    .PC_address  (PC_address),
`ifdef INS_MEM_WRITE_EN
    .wEn         (wEn),
    .wAddr       (wAddr),
    .wData       (wData),
`endif
    .instruction (instruction)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ren;
    logic [7:0] addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] a);
    rst = r; rEn = e; PC_address = a;
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[$];
  logic [7:0] img[16];
  logic [7:0] model;

  initial begin
    img = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
            8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'hFF};

    vecs.push_back('{1'b1, 1'b1, 8'h05, 8'h00, "reset_edge1"});
    vecs.push_back('{1'b1, 1'b1, 8'h05, 8'h00, "reset_edge2"});
    vecs.push_back('{1'b0, 1'b1, 8'h05, 8'h65, "mem_kept_after_reset"});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h10, "seq_0x00"});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h21, "seq_0x01"});
    vecs.push_back('{1'b0, 1'b1, 8'h0A, 8'hBA, "seq_0x0A"});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 8'h21, "hold_setup"});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 8'h21, "hold_ren0"});
    vecs.push_back('{1'b0, 1'b1, 8'h0A, 8'hBA, "after_hold"});
    vecs.push_back('{1'b0, 1'b1, 8'h0F, 8'hFF, "bound_0x0F"});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 8'h00, "bound_0x10"});
    vecs.push_back('{1'b0, 1'b1, 8'h0E, 8'hFE, "bound_0x0E"});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h00, "bound_0xFF"});
    vecs.push_back('{1'b0, 1'b1, 8'h07, 8'h87, "pre_midreset"});
    vecs.push_back('{1'b1, 1'b0, 8'h03, 8'h00, "reset_over_ren0"});
    vecs.push_back('{1'b0, 1'b0, 8'h03, 8'h00, "idle_after_reset"});
    vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h98, "first_fetch_after_reset"});

    rst = 1'b1; rEn = 1'b0; PC_address = 8'h00;
`ifdef INS_MEM_WRITE_EN
    wEn = 1'b0; wAddr = 8'h00; wData = 8'h00;
`endif
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ren, vecs[i].addr);
      check(vecs[i].name, instruction, vecs[i].exp);
    end

    // Random fetches against an independent model built from the image table.
    model = 8'h98;
    for (int k = 0; k < 10; k++) begin
      logic       e;
      logic [7:0] a;
      e = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 31));
      if (e) model = (a < 8'd16) ? img[a[3:0]] : 8'h00;
      step(1'b0, e, a);
      check($sformatf("random_%0d_a%02h_e%0b", k, a, e), instruction, model);
    end

`ifdef INS_MEM_WRITE_EN
    wEn = 1'b1; wAddr = 8'h20; wData = 8'h3C;
    step(1'b0, 1'b1, 8'h20);
    check("rbw_old_word", instruction, 8'h00);
    wEn = 1'b0;
    step(1'b0, 1'b1, 8'h20);
    check("write_visible", instruction, 8'h3C);
    wEn = 1'b1; wAddr = 8'h05; wData = 8'h55;
    step(1'b1, 1'b1, 8'h05);
    check("reset_with_wen", instruction, 8'h00);
    wEn = 1'b0;
    step(1'b0, 1'b1, 8'h05);
    check("write_blocked_in_reset", instruction, 8'h65);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
